// File: rtl/baby_core.sv
// baby_core: accumulator machine in the style of the Manchester Baby, with a req/ack store port.
// Build option BABY_EXT_ADD_EN: opcode 101 performs ADD instead of acting as a second SUB.
module baby_core #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_ni,
  input  logic [WORD_W-1:0] ram_data_i,
  output logic [WORD_W-1:0] ram_data_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_rw_en_o,
  output logic              ram_req_o,
  input  logic              ram_ack_i,
  input  logic              run_i,
  input  logic              step_i,
  output logic              stop_lamp_o
);

  typedef enum logic [2:0] {STOPPED, INC, FETCH, OPER, EXEC} state_t;

  localparam logic [2:0] OP_JMP     = 3'b000;
  localparam logic [2:0] OP_JRP     = 3'b100;
  localparam logic [2:0] OP_LDN     = 3'b010;
  localparam logic [2:0] OP_STO     = 3'b110;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_SUB_ALT = 3'b101;
  localparam logic [2:0] OP_CMP     = 3'b011;
  localparam logic [2:0] OP_STP     = 3'b111;

  state_t                    state, state_nxt;
  logic [1:0]                rst_sync;
  logic                      live;
  logic [ADDR_W-1:0]         ci, line;
  logic signed [WORD_W-1:0]  acc, opnd;
  logic [2:0]                op;
  logic                      stepped, run_q;
  logic                      acked, run_rise, start;
  logic                      do_start, do_inc, in_fetch, in_oper, do_exec, issue;

  function automatic logic signed [WORD_W-1:0] alu(
    input logic [2:0]               code,
    input logic signed [WORD_W-1:0] a,
    input logic signed [WORD_W-1:0] s
  );
    logic signed [WORD_W-1:0] r;
    r = a;
    case (code)
      OP_LDN: r = -s;
      OP_SUB: r = a - s;
`ifdef BABY_EXT_ADD_EN
      OP_SUB_ALT: r = a + s;
`else
      OP_SUB_ALT: r = a - s;
`endif
      default: r = a;
    endcase
    return r;
  endfunction

  // Jump targets use only the low address bits of the operand; CI wraps naturally.
  function automatic logic [ADDR_W-1:0] next_ci(
    input logic [2:0]               code,
    input logic [ADDR_W-1:0]        pc,
    input logic signed [WORD_W-1:0] s,
    input logic                     neg
  );
    logic [ADDR_W-1:0] r;
    r = pc;
    case (code)
      OP_JMP:  r = s[ADDR_W-1:0];
      OP_JRP:  r = pc + s[ADDR_W-1:0];
      OP_CMP:  r = neg ? pc + ADDR_W'(1) : pc;
      default: r = pc;
    endcase
    return r;
  endfunction

  // Reset asserts asynchronously but is released only on a clock edge.
  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign live = rst_sync[1];

  assign acked    = ram_req_o & ram_ack_i;
  assign run_rise = run_i & ~run_q;
  assign start    = run_rise | step_i;

  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni)  state <= STOPPED;
    else if (!live) state <= STOPPED;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STOPPED: if (start) state_nxt = INC;
      INC:     state_nxt = FETCH;
      FETCH:   if (acked) state_nxt = (ram_data_i[15:13] == OP_STP) ? STOPPED : OPER;
      OPER:    if (acked) state_nxt = EXEC;
      EXEC:    state_nxt = (run_i && !stepped) ? INC : STOPPED;
      default: state_nxt = STOPPED;
    endcase
  end

  always_comb begin
    stop_lamp_o = (state == STOPPED);
    do_start    = (state == STOPPED) && start;
    do_inc      = (state == INC);
    in_fetch    = (state == FETCH);
    in_oper     = (state == OPER);
    do_exec     = (state == EXEC);
    issue       = (in_fetch || in_oper) && !ram_req_o;
  end

  always_ff @(posedge clock or negedge reset_ni) begin
    if (!reset_ni) begin
      ci          <= '0;
      acc         <= '0;
      op          <= '0;
      line        <= '0;
      stepped     <= 1'b0;
      run_q       <= 1'b0;
      ram_req_o   <= 1'b0;
      ram_rw_en_o <= 1'b0;
      ram_addr_o  <= '0;
      ram_data_o  <= '0;
    end else begin
      run_q <= run_i;
      if (!live) begin
        ci          <= '0;
        acc         <= '0;
        op          <= '0;
        line        <= '0;
        stepped     <= 1'b0;
        ram_req_o   <= 1'b0;
        ram_rw_en_o <= 1'b0;
        ram_addr_o  <= '0;
        ram_data_o  <= '0;
      end else begin
        if (do_start) stepped <= step_i;
        if (do_inc)   ci <= ci + ADDR_W'(1);
        // Request is raised one cycle after entering FETCH/OPER, guaranteeing an idle gap.
        if (issue) begin
          ram_req_o <= 1'b1;
          if (in_fetch) begin
            ram_addr_o  <= ci;
            ram_rw_en_o <= 1'b0;
          end else begin
            ram_addr_o  <= line;
            ram_rw_en_o <= (op == OP_STO);
            ram_data_o  <= acc;
          end
        end
        if (acked) begin
          ram_req_o   <= 1'b0;
          ram_rw_en_o <= 1'b0;
          if (in_fetch) begin
            op   <= ram_data_i[15:13];
            line <= ram_data_i[ADDR_W-1:0];
          end
        end
        if (do_exec) begin
          acc <= alu(op, acc, opnd);
          ci  <= next_ci(op, ci, opnd, acc[WORD_W-1]);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (in_oper && acked) opnd <= ram_data_i;
  end

endmodule

// File: doc/baby_core.md
BABY_CORE -- requirements
Module: baby_core

Interface
REQ-001 The module SHALL have parameter WORD_W, default 32, meaning store word width in bits (legal 16..64).
REQ-002 The module SHALL have parameter ADDR_W, default 5, meaning store line-address width (legal 1..13; store depth 2^ADDR_W).
REQ-003 clock  input  1  sole clock, rising edge.
REQ-004 reset_ni  input  1  asynchronous, active-low reset.
REQ-005 ram_data_i  input  WORD_W  read data; valid only in a cycle with ram_ack_i high.
REQ-006 ram_data_o  output  WORD_W  write data (accumulator).
REQ-007 ram_addr_o  output  ADDR_W  store line address.
REQ-008 ram_rw_en_o  output  1  0 = read, 1 = write.
REQ-009 ram_req_o  output  1  store access request.
REQ-010 ram_ack_i  input  1  store access complete.
REQ-011 run_i  input  1  run switch (level).
REQ-012 step_i  input  1  single-step pulse.
REQ-013 stop_lamp_o  output  1  high while stopped.

Function
REQ-014 Instruction fields SHALL be line = bits [ADDR_W-1:0], opcode = bits [15:13]; all other bits are ignored.
REQ-015 Opcodes SHALL be: 000 JMP CI<=S; 100 JRP CI<=CI+S; 010 LDN A<=-S; 110 STO S<=A; 001 and 101 SUB A<=A-S; 011 CMP if A[WORD_W-1]=1 then CI<=CI+1; 111 STP. S is the word at the line field.
REQ-016 For JMP and JRP, S SHALL be truncated to its low ADDR_W bits; CI arithmetic SHALL wrap modulo 2^ADDR_W; A arithmetic SHALL wrap modulo 2^WORD_W.
REQ-017 States SHALL be STOPPED, INC, FETCH, OPER, EXEC.
REQ-018 Transitions: STOPPED->INC on a run_i rising edge or step_i high; INC->FETCH after 1 cycle (CI<=CI+1); FETCH->OPER on ack; OPER->EXEC on ack (STP goes FETCH->STOPPED directly); EXEC->INC if run_i high and the instruction was not single-stepped, else EXEC->STOPPED.
REQ-019 JMP, JRP, LDN, SUB and CMP SHALL read the operand in OPER; STO SHALL write in OPER, and its EXEC SHALL be a no-op.
REQ-020 The first instruction after reset SHALL be fetched from line 1 (increment-before-fetch).
REQ-021 Handshake: ram_req_o, ram_addr_o, ram_rw_en_o and ram_data_o SHALL stay stable from assertion until the cycle ram_ack_i is sampled high.
REQ-022 ram_req_o SHALL deassert for at least one cycle between accesses.
REQ-023 Zero-wait acknowledge (ram_ack_i high in the first request cycle) SHALL be supported.
REQ-024 ram_ack_i SHALL be ignored while ram_req_o is low.
REQ-025 run_i falling mid-instruction SHALL let the current instruction complete before entering STOPPED.
REQ-026 step_i is ignored outside STOPPED; run_i rising edge and step_i in the same cycle SHALL start one step only.
REQ-027 After STP, CI SHALL remain at the STP line; restart SHALL require a new run_i rising edge or step_i.
REQ-028 stop_lamp_o SHALL be high exactly in STOPPED.

Reset
REQ-029 While reset_ni is low: state STOPPED, CI=0, A=0, ram_req_o=0, ram_rw_en_o=0, ram_addr_o=0, ram_data_o=0, stop_lamp_o=1, run edge detector=0.
REQ-030 Reset asserted mid-access SHALL abandon the access immediately; a late ram_ack_i after reset is ignored.
REQ-031 Deassertion SHALL be synchronised internally and take effect on a clock edge; the first start needs a run_i rising edge seen after reset release.

Configuration
REQ-032 When BABY_EXT_ADD_EN is defined, opcode 101 SHALL execute ADD A<=A+S; when undefined, 101 SHALL execute SUB, identical to 001.

Verification
REQ-033 Reset, store line1=LDN 20, line2=STO 21, line3=STP, line20=5, run_i rise -> line21=0xFFFFFFFB, stop lamp high, CI=3.
REQ-034 A=-1, CMP then JMP 22 at next line -> JMP skipped; with A=0 -> CI=mem[22] (low 5 bits), next fetch from that value plus 1.
REQ-035 Slave ack latency 0, 1 and 7 cycles on every access -> identical final store contents; req and address stable until ack.
REQ-036 Stopped with step_i pulse and run_i low -> exactly one instruction executed, stop_lamp_o low then high again.
REQ-037 reset_ni pulsed low during an OPER write wait -> ram_req_o=0 asynchronously, CI=0, A=0, no write completes.
REQ-038 Opcode 101 with A=3, S=2 -> A=1 without BABY_EXT_ADD_EN, A=5 with it; also ADDR_W=8 build: JRP from 255 by 1 -> CI wraps to 0.
